// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg
// Shared definitions for the execution sequencer: data width, FSM state
// encoding, opcode/funct encodings, the instruction-class enum and small
// decode helpers used by both the sequencer and its next-pc unit.
package exec_sequencer_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WAIT,
        WB,
        HALT
    } state_t;

    // Opcodes live in instr[15:12]; 0..3 are conditional branches.
    localparam logic [3:0] OP_BR_LAST = 4'd3;
    localparam logic [3:0] OP_ADDI    = 4'd4;
    localparam logic [3:0] OP_IMMZ_A  = 4'd5;
    localparam logic [3:0] OP_IMMZ_B  = 4'd6;
    localparam logic [3:0] OP_LD      = 4'd7;
    localparam logic [3:0] OP_ST      = 4'd8;
    localparam logic [3:0] OP_JMP     = 4'd9;
    localparam logic [3:0] OP_JAL     = 4'd10;
    localparam logic [3:0] OP_RTYPE   = 4'd15;

    // R-type funct lives in instr[5:0]; 0..7 are register ALU operations.
    localparam logic [5:0] FN_ALU_LAST = 6'd7;
    localparam logic [5:0] FN_OUT      = 6'd25;
    localparam logic [5:0] FN_JR       = 6'd26;
    localparam logic [5:0] FN_HLT      = 6'd28;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU_R,
        CLS_IMM,
        CLS_MEM,
        CLS_OUT,
        CLS_JR,
        CLS_HLT,
        CLS_BR,
        CLS_JMP,
        CLS_JAL
    } cls_t;

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

    function automatic cls_t classify(input logic [3:0] op, input logic [5:0] fn);
        cls_t c;
        c = CLS_NOP;
        case (op)
            OP_ADDI, OP_IMMZ_A, OP_IMMZ_B: c = CLS_IMM;
            OP_LD, OP_ST:                  c = CLS_MEM;
            OP_JMP:                        c = CLS_JMP;
            OP_JAL:                        c = CLS_JAL;
            OP_RTYPE: begin
                if (fn <= FN_ALU_LAST)  c = CLS_ALU_R;
                else if (fn == FN_OUT)  c = CLS_OUT;
                else if (fn == FN_JR)   c = CLS_JR;
                else if (fn == FN_HLT)  c = CLS_HLT;
                else                    c = CLS_NOP;
            end
            default: c = (op <= OP_BR_LAST) ? CLS_BR : CLS_NOP;
        endcase
        return c;
    endfunction

    // Second ALU operand; jump targets keep the current 4K page of the pc.
    function automatic logic [DATA_W-1:0] operand2(input logic [15:0] ins,
                                                   input logic [3:0]  pc_hi,
                                                   input logic [15:0] rt);
        logic [DATA_W-1:0] r;
        case (ins[15:12])
            OP_RTYPE:              r = rt;
            OP_ADDI, OP_LD, OP_ST: r = sext8(ins[7:0]);
            OP_IMMZ_A, OP_IMMZ_B:  r = {8'h00, ins[7:0]};
            OP_JMP, OP_JAL:        r = {pc_hi, ins[11:0]};
            default:               r = (ins[15:12] <= OP_BR_LAST) ? rt : '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if
// Bundles the fetch, register-file, ALU and result signals of the sequencer.
//   master : the sequencer (drives requests, operands and result pulses)
//   slave  : the environment (instruction memory, register file, ALU)
interface exec_sequencer_if;
    import exec_sequencer_pkg::*;

    logic              instr_req;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [1:0]        rs_addr;
    logic [1:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] alu_input_1;
    logic [DATA_W-1:0] alu_input_2;
    logic [DATA_W-1:0] alu_instruction;
    logic              alu_input_ready;
    logic [DATA_W-1:0] alu_output;
    logic              branch_bit;
    logic              wb_en;
    logic [1:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic [DATA_W-1:0] output_port;
    logic              addr_valid;
    logic [DATA_W-1:0] mem_addr;
    logic              illegal;
    logic              halted;
    logic [DATA_W-1:0] instr_count;

    modport master (
        output instr_req, pc, rs_addr, rt_addr, alu_input_1, alu_input_2,
               alu_instruction, alu_input_ready, wb_en, wb_addr, wb_data,
               out_valid, output_port, addr_valid, mem_addr, illegal,
               halted, instr_count,
        input  instr_valid, instr, rs_data, rt_data, alu_output, branch_bit
    );

    modport slave (
        input  instr_req, pc, rs_addr, rt_addr, alu_input_1, alu_input_2,
               alu_instruction, alu_input_ready, wb_en, wb_addr, wb_data,
               out_valid, output_port, addr_valid, mem_addr, illegal,
               halted, instr_count,
        output instr_valid, instr, rs_data, rt_data, alu_output, branch_bit
    );

endinterface

// File: rtl/exec_sequencer_next_pc_unit.sv
// next_pc_unit
// Combinational next-pc selection, evaluated during write-back.
//   cls_i        : class of the instruction being retired
//   pc_i         : current pc
//   imm8_i       : branch displacement (instr[7:0])
//   alu_output_i : ALU result (jump target)
//   branch_bit_i : branch-taken flag from the ALU
//   pc_inc_o     : pc + 1 (also the link value for jump-and-link)
//   next_pc_o    : pc for the next fetch
module next_pc_unit
    import exec_sequencer_pkg::*;
(
    input  cls_t              cls_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [7:0]        imm8_i,
    input  logic [DATA_W-1:0] alu_output_i,
    input  logic              branch_bit_i,
    output logic [DATA_W-1:0] pc_inc_o,
    output logic [DATA_W-1:0] next_pc_o
);

    // All pc arithmetic is 16-bit and wraps naturally.
    assign pc_inc_o = pc_i + 16'd1;

    always_comb begin
        next_pc_o = pc_inc_o;
        case (cls_i)
            CLS_BR:                  if (branch_bit_i) next_pc_o = pc_inc_o + sext8(imm8_i);
            CLS_JMP, CLS_JAL, CLS_JR: next_pc_o = alu_output_i;
            CLS_HLT:                 next_pc_o = pc_i;
            default:                 next_pc_o = pc_inc_o;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WAIT -> WB,
// with HLT parking the machine in HALT until reset.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : fetch, register-file, ALU and result signals (master side)
module exec_sequencer
    import exec_sequencer_pkg::*;
(
    input logic              clk,
    input logic              reset_n,
    exec_sequencer_if.master bus
);

    state_t            state_q, state_d;
    logic              instr_req_q, instr_req_d;
    logic              alu_rdy_q, alu_rdy_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] alu_instr_q, alu_instr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;

    cls_t              cls;
    logic              in_wb;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] next_pc;

    assign cls   = classify(instr_q[15:12], instr_q[5:0]);
    assign in_wb = (state_q == WB);

    next_pc_unit u_next_pc (
        .cls_i        (cls),
        .pc_i         (pc_q),
        .imm8_i       (instr_q[7:0]),
        .alu_output_i (bus.alu_output),
        .branch_bit_i (bus.branch_bit),
        .pc_inc_o     (pc_inc),
        .next_pc_o    (next_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            instr_req_q <= 1'b0;
            alu_rdy_q   <= 1'b0;
            instr_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            alu_instr_q <= '0;
            pc_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            instr_req_q <= instr_req_d;
            alu_rdy_q   <= alu_rdy_d;
            instr_q     <= instr_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_instr_q <= alu_instr_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_instr_d = alu_instr_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        case (state_q)
            // instr_req is registered, so the cycle right after reset
            // release never accepts a word.
            FETCH: begin
                if (instr_req_q && bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                op1_d       = bus.rs_data;
                op2_d       = operand2(instr_q, pc_q[15:12], bus.rt_data);
                alu_instr_d = instr_q;
                state_d     = EXEC;
            end
            EXEC: state_d = WAIT;
            WAIT: state_d = WB;
            WB: begin
                cnt_d   = cnt_q + 16'd1;
                pc_d    = next_pc;
                state_d = (cls == CLS_HLT) ? HALT : FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        instr_req_d = (state_d == FETCH);
        alu_rdy_d   = (state_d == EXEC);
    end

    // Result pulses are decoded straight from the WB state so they can
    // never appear outside it and drop to zero the moment reset asserts.
    always_comb begin
        bus.wb_en       = 1'b0;
        bus.wb_addr     = 2'd0;
        bus.wb_data     = '0;
        bus.out_valid   = 1'b0;
        bus.output_port = '0;
        bus.addr_valid  = 1'b0;
        bus.mem_addr    = '0;
        bus.illegal     = 1'b0;
        if (in_wb) begin
            case (cls)
                CLS_ALU_R: begin
                    bus.wb_en   = 1'b1;
                    bus.wb_addr = instr_q[7:6];
                    bus.wb_data = bus.alu_output;
                end
                CLS_IMM: begin
                    bus.wb_en   = 1'b1;
                    bus.wb_addr = instr_q[9:8];
                    bus.wb_data = bus.alu_output;
                end
                CLS_JAL: begin
                    bus.wb_en   = 1'b1;
                    bus.wb_addr = 2'd2;
                    bus.wb_data = pc_inc;
                end
                CLS_MEM: begin
                    bus.addr_valid = 1'b1;
                    bus.mem_addr   = bus.alu_output;
                end
                CLS_OUT: begin
                    bus.out_valid   = 1'b1;
                    bus.output_port = bus.alu_output;
                end
                CLS_NOP: bus.illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.instr_req       = instr_req_q;
    assign bus.pc              = pc_q;
    assign bus.rs_addr         = instr_q[11:10];
    assign bus.rt_addr         = instr_q[9:8];
    assign bus.alu_input_1     = op1_q;
    assign bus.alu_input_2     = op2_q;
    assign bus.alu_instruction = alu_instr_q;
    assign bus.alu_input_ready = alu_rdy_q;
    assign bus.halted          = (state_q == HALT);
    assign bus.instr_count     = cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
// Directed bench: a table of instructions with hand-computed operands,
// result pulses and next pc, followed by HLT and reset-abort sequences.
module tb_exec_sequencer;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    exec_sequencer_if bus ();

    exec_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] alu;
        logic        br;
        logic        junk;   // keep instr_valid high with garbage after acceptance
        logic [15:0] op2;
        logic        wb;
        logic [1:0]  wba;
        logic [15:0] wbd;
        logic        outv;
        logic        addrv;
        logic        ill;
        logic [15:0] pc;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a fetch request, then present one word for one edge.
    task automatic issue(input logic [15:0] ins, input logic [15:0] rs, input logic [15:0] rt,
                         input logic [15:0] alu, input logic br, input string tag);
        int guard;
        guard = 0;
        while (bus.instr_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " instr_req before issue"}, 16'(bus.instr_req), 16'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        bus.rs_data     = rs;
        bus.rt_data     = rt;
        bus.alu_output  = alu;
        bus.branch_bit  = br;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, rdy_n, wb_n, out_n, addr_n, ill_n;
        logic [15:0] op1_s, op2_s, ains_s, wbd_s, outp_s, mema_s;
        logic [1:0]  wba_s;
        string tag;
        tag = $sformatf("v%0d", idx);
        rdy_n = 0; wb_n = 0; out_n = 0; addr_n = 0; ill_n = 0;
        op1_s = 'x; op2_s = 'x; ains_s = 'x; wbd_s = 'x; outp_s = 'x; mema_s = 'x; wba_s = 'x;
        issue(v.instr, v.rs, v.rt, v.alu, v.br, tag);
        if (v.junk) bus.instr = 16'hC0DE;
        else        bus.instr_valid = 1'b0;
        for (cyc = 1; cyc <= 12; cyc++) begin
            if (bus.alu_input_ready === 1'b1) begin
                rdy_n++;
                op1_s  = bus.alu_input_1;
                op2_s  = bus.alu_input_2;
                ains_s = bus.alu_instruction;
            end
            if (bus.wb_en === 1'b1) begin
                wb_n++;
                wba_s = bus.wb_addr;
                wbd_s = bus.wb_data;
            end
            if (bus.out_valid === 1'b1) begin
                out_n++;
                outp_s = bus.output_port;
            end
            if (bus.addr_valid === 1'b1) begin
                addr_n++;
                mema_s = bus.mem_addr;
            end
            if (bus.illegal === 1'b1) ill_n++;
            if (bus.instr_req === 1'b1 || bus.halted === 1'b1) break;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        check({tag, " cycles to next request"}, 16'(cyc), 16'd5);
        check({tag, " ready pulses"}, 16'(rdy_n), 16'd1);
        check({tag, " alu_input_1"}, op1_s, v.rs);
        check({tag, " alu_input_2"}, op2_s, v.op2);
        check({tag, " alu_instruction"}, ains_s, v.instr);
        check({tag, " wb_en pulses"}, 16'(wb_n), 16'(v.wb));
        if (v.wb) begin
            check({tag, " wb_addr"}, 16'(wba_s), 16'(v.wba));
            check({tag, " wb_data"}, wbd_s, v.wbd);
        end
        check({tag, " out_valid pulses"}, 16'(out_n), 16'(v.outv));
        if (v.outv) check({tag, " output_port"}, outp_s, v.alu);
        check({tag, " addr_valid pulses"}, 16'(addr_n), 16'(v.addrv));
        if (v.addrv) check({tag, " mem_addr"}, mema_s, v.alu);
        check({tag, " illegal pulses"}, 16'(ill_n), 16'(v.ill));
        check({tag, " pc"}, bus.pc, v.pc);
        check({tag, " instr_count"}, bus.instr_count, 16'(idx + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_n, wb_n, guard;
        reset_n         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.rs_data     = 16'h0000;
        bus.rt_data     = 16'h0000;
        bus.alu_output  = 16'h0000;
        bus.branch_bit  = 1'b0;

        //          instr     rs        rt        alu       br    junk  op2       wb    wba   wbd       outv  addrv ill   pc
        vecs[0]  = '{16'hF180, 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0, 16'h0005, 1'b1, 2'd2, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h0001};
        vecs[1]  = '{16'h41FF, 16'h0005, 16'h1234, 16'h0004, 1'b0, 1'b1, 16'hFFFF, 1'b1, 2'd1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0002};
        vecs[2]  = '{16'h5280, 16'h0007, 16'h0000, 16'h0087, 1'b0, 1'b0, 16'h0080, 1'b1, 2'd2, 16'h0087, 1'b0, 1'b0, 1'b0, 16'h0003};
        vecs[3]  = '{16'h7C90, 16'h0100, 16'h0000, 16'h0090, 1'b0, 1'b0, 16'hFF90, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0004};
        vecs[4]  = '{16'hF019, 16'hABCD, 16'h1111, 16'hABCD, 1'b0, 1'b0, 16'h1111, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0005};
        vecs[5]  = '{16'hC000, 16'h2222, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0006};
        vecs[6]  = '{16'hF03F, 16'h4444, 16'h3333, 16'h0000, 1'b0, 1'b0, 16'h3333, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0007};
        vecs[7]  = '{16'h9010, 16'h0000, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0010, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010};
        vecs[8]  = '{16'h0103, 16'h0006, 16'h0006, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0014};
        vecs[9]  = '{16'h0103, 16'h0006, 16'h0006, 16'h0000, 1'b0, 1'b0, 16'h0006, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0015};
        vecs[10] = '{16'h9020, 16'h0000, 16'h0000, 16'h0020, 1'b0, 1'b0, 16'h0020, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0020};
        vecs[11] = '{16'hA005, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b0, 16'h0005, 1'b1, 2'd2, 16'h0021, 1'b0, 1'b0, 1'b0, 16'h0005};
        vecs[12] = '{16'hF01A, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0001, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF};
        vecs[13] = '{16'hC000, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[14] = '{16'h01FE, 16'h0000, 16'h0007, 16'h0000, 1'b1, 1'b0, 16'h0007, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF};
        vecs[15] = '{16'h9123, 16'h0000, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 16'hF123, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFE};
        vecs[16] = '{16'h0001, 16'h0000, 16'h0009, 16'h0000, 1'b1, 1'b0, 16'h0009, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[17] = '{16'h8405, 16'h0300, 16'h0000, 16'h0305, 1'b0, 1'b0, 16'h0005, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0001};
        vecs[18] = '{16'h6305, 16'h0000, 16'h0000, 16'h0AAA, 1'b0, 1'b0, 16'h0005, 1'b1, 2'd3, 16'h0AAA, 1'b0, 1'b0, 1'b0, 16'h0002};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset instr_req", 16'(bus.instr_req), 16'd0);
        check("reset pc", bus.pc, 16'h0000);
        check("reset instr_count", bus.instr_count, 16'h0000);
        check("reset halted", 16'(bus.halted), 16'd0);
        check("reset alu_input_ready", 16'(bus.alu_input_ready), 16'd0);
        check("reset wb_en", 16'(bus.wb_en), 16'd0);
        check("reset alu_input_1", bus.alu_input_1, 16'h0000);
        reset_n = 1'b1;
        #1;
        check("instr_req right at release", 16'(bus.instr_req), 16'd0);
        @(negedge clk);
        check("instr_req one cycle after release", 16'(bus.instr_req), 16'd1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // HLT: stays halted, no further fetches, instruction still counted
        issue(16'hF01C, 16'h0000, 16'h0000, 16'h0000, 1'b0, "hlt");
        bus.instr_valid = 1'b0;
        guard = 0;
        wb_n  = 0;
        while (bus.halted !== 1'b1 && guard < 12) begin
            if (bus.wb_en === 1'b1) wb_n++;
            @(negedge clk);
            guard++;
        end
        check("hlt halted", 16'(bus.halted), 16'd1);
        check("hlt wb_en pulses", 16'(wb_n), 16'd0);
        check("hlt instr_count", bus.instr_count, 16'(NV + 1));
        req_n = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'hF180;
        for (int c = 0; c < 100; c++) begin
            if (bus.instr_req === 1'b1) req_n++;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        check("hlt instr_req cycles in 100", 16'(req_n), 16'd0);
        check("hlt still halted", 16'(bus.halted), 16'd1);

        // Reset leaves HALT
        reset_n = 1'b0;
        #1;
        check("reset from halt halted", 16'(bus.halted), 16'd0);
        check("reset from halt pc", bus.pc, 16'h0000);
        check("reset from halt instr_count", bus.instr_count, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("instr_req after halt reset", 16'(bus.instr_req), 16'd1);

        // Reset during EXEC aborts without writeback
        issue(16'hF180, 16'h0003, 16'h0005, 16'h0008, 1'b0, "abort");
        bus.instr_valid = 1'b0;
        guard = 0;
        while (bus.alu_input_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check("abort reached EXEC", 16'(bus.alu_input_ready), 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort alu_input_ready drops", 16'(bus.alu_input_ready), 16'd0);
        check("abort instr_req in reset", 16'(bus.instr_req), 16'd0);
        wb_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.wb_en === 1'b1) wb_n++;
        end
        reset_n = 1'b1;
        #1;
        if (bus.wb_en === 1'b1) wb_n++;
        check("abort instr_req right at release", 16'(bus.instr_req), 16'd0);
        @(negedge clk);
        if (bus.wb_en === 1'b1) wb_n++;
        check("abort wb_en pulses", 16'(wb_n), 16'd0);
        check("abort instr_req one cycle after release", 16'(bus.instr_req), 16'd1);
        check("abort pc", bus.pc, 16'h0000);
        check("abort instr_count", bus.instr_count, 16'h0000);

        // Normal operation resumes from pc 0
        run_vec(vecs[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
